regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Schedules the single register-file write port between two sources. The pipeline
//  writeback (WB) source has priority; a long-latency unit (LL: mult/div/CP0) is
//  held pending, with a starvation limit. Decodes the destination select (rt/rd/$31)
//  into a 5-bit address and registers rf_we/rf_waddr/rf_wdata.
//  Sits between the WB stage and the register file.
// PARAMETERS
//  STARVE_MAX  8   cycles an LL request may wait before it is force-granted (1..255)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   synchronous, active-high reset
//  wb_valid     in   1   WB stage has a write this cycle (one-shot; never held)
//  wb_sel       in   2   dest select: 00=rt, 01=rd, 10/11=$31
//  wb_rt        in   5   rt field
//  wb_rd        in   5   rd field
//  wb_data      in   32  WB write data
//  ll_valid     in   1   LL result valid; held with ll_addr/ll_data stable until ll_ready
//  ll_addr      in   5   LL destination register
//  ll_data      in   32  LL result
//  ll_ready     out  1   LL result accepted this cycle (combinational)
//  wb_stall     out  1   stall pipeline: WB slot consumed by forced LL write
//  ll_busy_addr out  5   dest of the pending LL request (0 when none)
//  rf_we        out  1   register-file write enable (registered)
//  rf_waddr     out  5   register-file write address (registered)
//  rf_wdata     out  32  register-file write data (registered)
// BEHAVIOUR
//  - Reset: state=IDLE, wait counter=0; rf_we=0, rf_waddr=0, rf_wdata=0; ll_ready=0,
//    wb_stall=0, ll_busy_addr=0.
//  - Dest decode: 00->wb_rt, 01->wb_rd, 1x->5'd31. Done in the same cycle as wb_valid.
//  - Latency: the winner's write appears on rf_* exactly 1 cycle after the grant.
//  - $0 rule: a grant to address 0 is consumed (ll_ready or the WB slot is used), but
//    rf_we=0 that cycle.
//  - FSM states:
//    IDLE: ll_valid & !wb_valid -> grant LL (ll_ready=1), stay IDLE.
//          ll_valid & wb_valid  -> grant WB, cnt<=1, go to PEND.
//          Otherwise grant WB if wb_valid.
//    PEND: !wb_valid -> grant LL, cnt<=0, go to IDLE.
//          wb_valid & cnt<STARVE_MAX -> grant WB, cnt++.
//          wb_valid & cnt==STARVE_MAX -> go to FORCE. WB is still granted this cycle.
//    FORCE: wb_stall=1, grant LL, cnt<=0, go to IDLE. The pipeline must not present
//           wb_valid while wb_stall=1. If it does, that WB write is dropped (protocol
//           violation, asserted in simulation).
//  - ll_busy_addr = ll_addr while ll_valid & !ll_ready, else 0. The hazard unit uses it.
//  - ll_valid deasserting in PEND/FORCE is illegal (assert). The FSM returns to IDLE
//    without a write.
//  - rst asserted mid-PEND/FORCE: the pending LL grant is discarded, and all state and
//    outputs return to their reset values on that edge. The LL source re-presents
//    after reset.
//  - Same-address collision (WB and LL to the same register, both pending): order is
//    grant order. The later write wins in the register file.
// CONFIGURATION
//  WB_ARB_FWD_EN defined: adds outputs fwd_valid(1), fwd_addr(5), fwd_data(32). These
//    are combinational copies of the granted write this cycle, with fwd_valid=0 for
//    $0. They allow same-cycle bypass to ID.
//  WB_ARB_FWD_EN undefined: these ports are absent, and the write is visible only via
//    rf_* one cycle later.
// STRUCTURE
//  - Package wb_arb_pkg: state typedef {IDLE, PEND, FORCE}; SEL_RT=2'b00, SEL_RD=2'b01,
//    SEL_RA=2'b10; REG_RA=5'd31; REG_ZERO=5'd0.
//  - Sub-module wb_dest_sel: pure combinational wb_sel/wb_rt/wb_rd -> 5-bit address.
//  - Remaining logic (FSM, counter, output registers) is in this module.
// TESTING
//  1. Reset: assert rst 2 cycles with random inputs -> rf_we=0, rf_waddr=0, ll_ready=0,
//     wb_stall=0.
//  2. Decode: wb_valid with sel=00/01/10, rt=5, rd=9, data=0xA5A5_0001 -> next cycle
//     rf_waddr=5/9/31, rf_we=1, rf_wdata=0xA5A5_0001.
//  3. Arbitration: wb_valid and ll_valid (addr=12) together, then WB idle for 1 cycle
//     -> WB written first, ll_ready pulses on the next cycle, and rf_waddr=12 a cycle
//     later.
//  4. Starvation (STARVE_MAX=8): ll_valid held, wb_valid every cycle -> 9 WB grants,
//     then wb_stall=1 for exactly one cycle, ll_ready=1 in that cycle, and the LL write
//     appears one cycle later.
//  5. $0 write: sel=00, rt=0 -> rf_we stays 0. ll_addr=0 -> ll_ready=1 and rf_we=0.
//  6. Reset mid-PEND: rst in the cycle after entering PEND -> no LL write, and
//     ll_busy_addr returns to 0 after the reset.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Holds the FSM state type, destination-select codes and fixed register numbers.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    FORCE
  } state_t;

  localparam logic [1:0] SEL_RT = 2'b00;
  localparam logic [1:0] SEL_RD = 2'b01;
  localparam logic [1:0] SEL_RA = 2'b10;

  localparam logic [4:0] REG_RA   = 5'd31;
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_dest_sel.sv
// Combinational destination-register decode for the WB source.
// Ports: sel (2b select), rt/rd (5b fields) in; addr (5b) out. 1x selects $31.
module wb_dest_sel
  import wb_arb_pkg::*;
(
  input  logic [1:0] sel,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  output logic [4:0] addr
);

  always_comb begin
    case (sel)
      SEL_RT:  addr = rt;
      SEL_RD:  addr = rd;
      default: addr = REG_RA;
    endcase
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between WB (priority) and an LL unit.
// In: clk, rst (sync, active-high), wb_valid/sel/rt/rd/data, ll_valid/addr/data.
// Out: ll_ready, wb_stall, ll_busy_addr (comb); rf_we/rf_waddr/rf_wdata (registered).
// Optional macro WB_ARB_FWD_EN adds fwd_valid/fwd_addr/fwd_data same-cycle bypass.
module regfile_wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [1:0]  wb_sel,
  input  logic [4:0]  wb_rt,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        ll_valid,
  input  logic [4:0]  ll_addr,
  input  logic [31:0] ll_data,
  output logic        ll_ready,
  output logic        wb_stall,
  output logic [4:0]  ll_busy_addr,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
`ifdef WB_ARB_FWD_EN
  ,
  output logic        fwd_valid,
  output logic [4:0]  fwd_addr,
  output logic [31:0] fwd_data
`endif
);

  localparam logic [7:0] CNT_MAX = 8'(STARVE_MAX);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        gnt_wb, gnt_ll, stall;
  logic        gnt_any;
  logic [4:0]  wb_addr, g_addr;
  logic [31:0] g_data;

  wb_dest_sel u_dest (
    .sel  (wb_sel),
    .rt   (wb_rt),
    .rd   (wb_rd),
    .addr (wb_addr)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gnt_wb    = 1'b0;
    gnt_ll    = 1'b0;
    stall     = 1'b0;
    unique case (state)
      IDLE: begin
        if (ll_valid && !wb_valid) begin
          gnt_ll = 1'b1;
        end else if (ll_valid) begin
          gnt_wb    = 1'b1;
          cnt_nxt   = 8'd1;
          state_nxt = PEND;
        end else begin
          gnt_wb = wb_valid;
        end
      end
      PEND: begin
        if (!ll_valid) begin
          // LL vanished: abandon it, WB still gets the port
          gnt_wb    = wb_valid;
          cnt_nxt   = 8'd0;
          state_nxt = IDLE;
        end else if (!wb_valid) begin
          gnt_ll    = 1'b1;
          cnt_nxt   = 8'd0;
          state_nxt = IDLE;
        end else if (cnt < CNT_MAX) begin
          gnt_wb  = 1'b1;
          cnt_nxt = cnt + 8'd1;
        end else begin
          gnt_wb    = 1'b1;
          state_nxt = FORCE;
        end
      end
      FORCE: begin
        // WB slot is stolen; any WB presented now is dropped
        stall     = 1'b1;
        gnt_ll    = ll_valid;
        cnt_nxt   = 8'd0;
        state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = 8'd0;
        state_nxt = IDLE;
      end
    endcase
    if (rst) begin
      gnt_wb = 1'b0;
      gnt_ll = 1'b0;
      stall  = 1'b0;
    end
  end

  assign gnt_any = gnt_wb | gnt_ll;
  assign g_addr  = gnt_ll ? ll_addr : wb_addr;
  assign g_data  = gnt_ll ? ll_data : wb_data;

  assign ll_ready     = gnt_ll;
  assign wb_stall     = stall;
  assign ll_busy_addr = (ll_valid && !gnt_ll && !rst) ? ll_addr : REG_ZERO;

`ifdef WB_ARB_FWD_EN
  assign fwd_valid = gnt_any && (g_addr != REG_ZERO);
  assign fwd_addr  = g_addr;
  assign fwd_data  = g_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      rf_we    <= 1'b0;
      rf_waddr <= REG_ZERO;
      rf_wdata <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rf_we <= gnt_any && (g_addr != REG_ZERO);
      if (gnt_any) begin
        rf_waddr <= g_addr;
        rf_wdata <= g_data;
      end
      if (state == FORCE) assert (!wb_valid);
      if (state != IDLE) assert (ll_valid);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed cases plus random traffic.
// A per-cycle reference model predicts every output; one process compares it.
module tb_regfile_wb_arbiter;

  localparam int SMAX = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0;
  logic [1:0]  wb_sel = 2'd0;
  logic [4:0]  wb_rt = 5'd0;
  logic [4:0]  wb_rd = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic        ll_valid = 1'b0;
  logic [4:0]  ll_addr = 5'd0;
  logic [31:0] ll_data = 32'd0;
  logic        ll_ready, wb_stall, rf_we;
  logic [4:0]  ll_busy_addr, rf_waddr;
  logic [31:0] rf_wdata;
`ifdef WB_ARB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
`endif

  regfile_wb_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .wb_sel       (wb_sel),
    .wb_rt        (wb_rt),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .ll_valid     (ll_valid),
    .ll_addr      (ll_addr),
    .ll_data      (ll_data),
    .ll_ready     (ll_ready),
    .wb_stall     (wb_stall),
    .ll_busy_addr (ll_busy_addr),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata)
`ifdef WB_ARB_FWD_EN
    ,
    .fwd_valid    (fwd_valid),
    .fwd_addr     (fwd_addr),
    .fwd_data     (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // model: consecutive denials of the current LL request
  int          denied = 0;
  bit          e_ready, e_stall, e_fv;
  logic [4:0]  e_busy, e_faddr;
  logic [31:0] e_fdata;
  bit          p_we = 1'b0;
  logic [4:0]  p_addr = 5'd0;
  logic [31:0] p_data = 32'd0;
  bit          x_we = 1'b0;
  logic [4:0]  x_addr = 5'd0;
  logic [31:0] x_data = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit wbv, input logic [1:0] sel,
                     input logic [4:0] rt, input logic [4:0] rd,
                     input logic [31:0] wd, input bit llv,
                     input logic [4:0] la, input logic [31:0] ld);
    bit forced, g_ll, g_wb;
    logic [4:0] wa, ga;
    logic [31:0] gd;
    @(posedge clk);
    #1;
    x_we   = p_we;
    x_addr = p_addr;
    x_data = p_data;
    forced = !r && llv && (denied == SMAX + 1);
    rst      = r;
    wb_valid = wbv && !forced;
    wb_sel   = sel;
    wb_rt    = rt;
    wb_rd    = rd;
    wb_data  = wd;
    ll_valid = llv;
    ll_addr  = la;
    ll_data  = ld;
    e_ready = 1'b0;
    e_stall = 1'b0;
    e_busy  = 5'd0;
    e_fv    = 1'b0;
    e_faddr = 5'd0;
    e_fdata = 32'd0;
    if (r) begin
      denied = 0;
      p_we   = 1'b0;
      p_addr = 5'd0;
      p_data = 32'd0;
    end else begin
      wa = (sel == 2'd0) ? rt : (sel == 2'd1) ? rd : 5'd31;
      g_ll = 1'b0;
      g_wb = 1'b0;
      if (forced) begin
        e_stall = 1'b1;
        g_ll = 1'b1;
      end else if (llv && wbv) begin
        g_wb = 1'b1;
        denied++;
      end else if (llv) begin
        g_ll = 1'b1;
      end else if (wbv) begin
        g_wb = 1'b1;
      end
      if (!llv || g_ll) denied = 0;
      ga = g_ll ? la : wa;
      gd = g_ll ? ld : wd;
      e_ready = g_ll;
      e_busy  = (llv && !g_ll) ? la : 5'd0;
      e_fv    = (g_ll || g_wb) && (ga != 5'd0);
      e_faddr = ga;
      e_fdata = gd;
      p_we = (g_ll || g_wb) && (ga != 5'd0);
      if (g_ll || g_wb) begin
        p_addr = ga;
        p_data = gd;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ll_ready", 32'(ll_ready), 32'(e_ready));
      chk("wb_stall", 32'(wb_stall), 32'(e_stall));
      chk("ll_busy_addr", 32'(ll_busy_addr), 32'(e_busy));
      chk("rf_we", 32'(rf_we), 32'(x_we));
      chk("rf_waddr", 32'(rf_waddr), 32'(x_addr));
      chk("rf_wdata", rf_wdata, x_data);
`ifdef WB_ARB_FWD_EN
      chk("fwd_valid", 32'(fwd_valid), 32'(e_fv));
      if (e_fv) begin
        chk("fwd_addr", 32'(fwd_addr), 32'(e_faddr));
        chk("fwd_data", fwd_data, e_fdata);
      end
`endif
    end
  end

  initial begin
    int ns, si;
    bit sr, done, llp, r, wbv;
    int wbp;
    logic [4:0]  la;
    logic [31:0] ld;
    bit          a_we[11];
    logic [4:0]  a_addr[11];

    // reset with random inputs
    cyc(1, 1'($urandom), 2'($urandom), 5'($urandom), 5'($urandom),
        $urandom, 1'($urandom), 5'($urandom), $urandom);
    cyc(1, 1'($urandom), 2'($urandom), 5'($urandom), 5'($urandom),
        $urandom, 1'($urandom), 5'($urandom), $urandom);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_ll_ready", 32'(ll_ready), 32'd0);
    chk("rst_wb_stall", 32'(wb_stall), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);

    // decode
    cyc(0, 1, 2'b00, 5'd5, 5'd9, 32'hA5A5_0001, 0, 5'd0, 32'd0);
    cyc(0, 1, 2'b01, 5'd5, 5'd9, 32'hA5A5_0001, 0, 5'd0, 32'd0);
    @(negedge clk);
    chk("dec_rt_addr", 32'(rf_waddr), 32'd5);
    chk("dec_rt_we", 32'(rf_we), 32'd1);
    chk("dec_rt_data", rf_wdata, 32'hA5A5_0001);
    cyc(0, 1, 2'b10, 5'd5, 5'd9, 32'hA5A5_0001, 0, 5'd0, 32'd0);
    @(negedge clk);
    chk("dec_rd_addr", 32'(rf_waddr), 32'd9);
    cyc(0, 0, 2'b00, 5'd0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    @(negedge clk);
    chk("dec_ra_addr", 32'(rf_waddr), 32'd31);
    chk("dec_ra_we", 32'(rf_we), 32'd1);

    // arbitration: WB first, LL next
    cyc(0, 1, 2'b01, 5'd0, 5'd7, 32'h1111_0007, 1, 5'd12, 32'h2222_000C);
    @(negedge clk);
    chk("arb_busy", 32'(ll_busy_addr), 32'd12);
    chk("arb_rdy0", 32'(ll_ready), 32'd0);
    cyc(0, 0, 2'b00, 5'd0, 5'd0, 32'd0, 1, 5'd12, 32'h2222_000C);
    @(negedge clk);
    chk("arb_rdy1", 32'(ll_ready), 32'd1);
    chk("arb_wb_addr", 32'(rf_waddr), 32'd7);
    cyc(0, 0, 2'b00, 5'd0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    @(negedge clk);
    chk("arb_ll_addr", 32'(rf_waddr), 32'd12);
    chk("arb_ll_data", rf_wdata, 32'h2222_000C);

    // starvation
    ns = 0;
    si = -1;
    sr = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 11; i++) begin
      cyc(0, 1, 2'b00, 5'd3, 5'd0, 32'h3300_0000 + 32'(i),
          !done, 5'd20, 32'hBEEF_0000);
      @(negedge clk);
      if (wb_stall) begin
        ns++;
        si = i;
        sr = ll_ready;
      end
      if (ll_ready) done = 1'b1;
      a_we[i]   = rf_we;
      a_addr[i] = rf_waddr;
    end
    chk("starve_stalls", 32'(ns), 32'd1);
    chk("starve_idx", 32'(si), 32'd9);
    chk("starve_rdy", 32'(sr), 32'd1);
    chk("starve_ll_we", 32'(a_we[10]), 32'd1);
    chk("starve_ll_addr", 32'(a_addr[10]), 32'd20);

    // $0 writes
    cyc(0, 1, 2'b00, 5'd0, 5'd4, 32'h0000_DEAD, 0, 5'd0, 32'd0);
    cyc(0, 0, 2'b00, 5'd0, 5'd0, 32'd0, 1, 5'd0, 32'h0000_BEEF);
    @(negedge clk);
    chk("zero_wb_we", 32'(rf_we), 32'd0);
    chk("zero_ll_rdy", 32'(ll_ready), 32'd1);
    cyc(0, 0, 2'b00, 5'd0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    @(negedge clk);
    chk("zero_ll_we", 32'(rf_we), 32'd0);

    // reset mid-PEND
    cyc(0, 1, 2'b01, 5'd0, 5'd6, 32'h0606_0606, 1, 5'd14, 32'h1414_1414);
    cyc(1, 0, 2'b00, 5'd0, 5'd0, 32'd0, 1, 5'd14, 32'h1414_1414);
    cyc(0, 0, 2'b00, 5'd0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    @(negedge clk);
    chk("rstp_we", 32'(rf_we), 32'd0);
    chk("rstp_busy", 32'(ll_busy_addr), 32'd0);
    cyc(0, 0, 2'b00, 5'd0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    @(negedge clk);
    chk("rstp_no_ll", 32'(rf_we), 32'd0);

    // random traffic with bursty WB phases
    llp = 1'b0;
    la = 5'd0;
    ld = 32'd0;
    for (int i = 0; i < 3000; i++) begin
      case ((i / 300) % 4)
        1: wbp = 97;
        3: wbp = 30;
        default: wbp = 65;
      endcase
      r   = ($urandom_range(0, 149) == 0);
      wbv = ($urandom_range(0, 99) < wbp);
      if (!llp && $urandom_range(0, 99) < 35) begin
        llp = 1'b1;
        la  = 5'($urandom);
        ld  = $urandom;
      end
      cyc(r, wbv, 2'($urandom), 5'($urandom), 5'($urandom), $urandom,
          llp, la, ld);
      if (e_ready) llp = 1'b0;
    end
    cyc(0, 0, 2'b00, 5'd0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
